// File: rtl/silife_max7219_sink.sv
// Receive-side model of a MAX7219 daisy chain: oversamples CS/SCK/DIN, shifts a
// 16*CHAIN chain register and latches each device's word into its register file on CS rise.

module silife_max7219_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch,
  input  logic [15:0] word,
  input  logic [3:0]  rd_addr,
  input  logic [2:0]  rd_row,
  output logic [7:0]  rd_data,
  output logic [7:0]  row
);
  logic [7:0] digit [8];
  logic [7:0] decode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n;
  logic       test;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) digit[i] <= 8'h00;
      decode     <= 8'h00;
      intensity  <= 4'h0;
      scan_limit <= 3'h0;
      shutdown_n <= 1'b0;
      test       <= 1'b0;
    end else if (latch) begin
      // bits 15:12 are don't-care on the real part
      case (word[11:8])
        4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8: digit[3'(word[11:8] - 4'd1)] <= word[7:0];
        4'h9: decode     <= word[7:0];
        4'hA: intensity  <= word[3:0];
        4'hB: scan_limit <= word[2:0];
        4'hC: shutdown_n <= word[0];
        4'hF: test       <= word[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8: rd_data = digit[3'(rd_addr - 4'd1)];
      4'h9: rd_data = decode;
      4'hA: rd_data = {4'h0, intensity};
      4'hB: rd_data = {5'h00, scan_limit};
      4'hC: rd_data = {7'h00, shutdown_n};
      4'hF: rd_data = {7'h00, test};
      default: rd_data = 8'h00;
    endcase
  end

  assign row = digit[rd_row];
endmodule

module silife_max7219_sink #(
  parameter int CHAIN    = 4,
  parameter int DEV_BITS = (CHAIN > 1) ? $clog2(CHAIN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cs,
  input  logic                  i_sck,
  input  logic                  i_mosi,
  input  logic [DEV_BITS-1:0]   i_rd_dev,
  input  logic [3:0]            i_rd_addr,
  input  logic [2:0]            i_rd_row,
  output logic [7:0]            o_rd_data,
  output logic [8*CHAIN-1:0]    o_row,
  output logic                  o_dout,
  output logic                  o_frame,
  output logic                  o_frame_err
);
  localparam int W = 16 * CHAIN;

  // [0]=sync1, [1]=sync2, [2]=history; MOSI needs no history
  logic [2:0]   cs_p, sck_p;
  logic [1:0]   mosi_p;
  logic [W-1:0] chain;
  logic [3:0]   cnt;
  logic         nz;

  logic shift, cs_fall, cs_rise, latch;
  assign shift   = sck_p[1] & ~sck_p[2] & ~cs_p[1];
  assign cs_fall = cs_p[2] & ~cs_p[1];
  assign cs_rise = ~cs_p[2] & cs_p[1];
  assign latch   = cs_rise & nz;
  assign o_dout  = chain[W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_p        <= 3'b111;
      sck_p       <= 3'b000;
      mosi_p      <= 2'b00;
      chain       <= '0;
      cnt         <= 4'h0;
      nz          <= 1'b0;
      o_frame     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      cs_p        <= {cs_p[1:0], i_cs};
      sck_p       <= {sck_p[1:0], i_sck};
      mosi_p      <= {mosi_p[0], i_mosi};
      o_frame     <= latch;
      o_frame_err <= latch & (cnt != 4'h0);
      if (shift) chain <= {chain[W-2:0], mosi_p[1]};
      // an SCK rise in the same sample as the CS fall still counts as bit 1
      cnt <= (cs_fall ? 4'h0 : cnt) + {3'b000, shift};
      nz  <= (cs_fall ? 1'b0 : nz) | shift;
    end
  end

  logic [CHAIN-1:0][7:0] dev_data, dev_row;
  logic [8*CHAIN-1:0]    row_n;

  for (genvar d = 0; d < CHAIN; d++) begin : g_dev
    silife_max7219_dev u_dev (
      .clk     (clk),
      .reset   (reset),
      .latch   (latch),
      .word    (chain[16*d +: 16]),
      .rd_addr (i_rd_addr),
      .rd_row  (i_rd_row),
      .rd_data (dev_data[d]),
      .row     (dev_row[d])
    );
    assign row_n[8*d +: 8] = dev_row[CHAIN-1-d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rd_data <= 8'h00;
      o_row     <= '0;
    end else begin
      o_rd_data <= dev_data[i_rd_dev];
      o_row     <= row_n;
    end
  end
endmodule

// File: tb/tb_silife_max7219_sink.sv
// Directed bench for silife_max7219_sink (CHAIN=4): bit-banged frames, register and row reads.

module tb_silife_max7219_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_cs, i_sck, i_mosi;
  logic [1:0]  i_rd_dev;
  logic [3:0]  i_rd_addr;
  logic [2:0]  i_rd_row;
  logic [7:0]  o_rd_data;
  logic [31:0] o_row;
  logic        o_dout, o_frame, o_frame_err;

  int checks = 0, failures = 0;
  int nf = 0, ne = 0, nbad = 0;
  int f0, e0;

  silife_max7219_sink #(.CHAIN(4)) dut (
    .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .i_rd_dev(i_rd_dev), .i_rd_addr(i_rd_addr), .i_rd_row(i_rd_row),
    .o_rd_data(o_rd_data), .o_row(o_row), .o_dout(o_dout),
    .o_frame(o_frame), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame) nf++;
    if (o_frame_err) ne++;
    if (o_frame_err && !o_frame) nbad++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_mosi = b;
    wclk(4);
    i_sck = 1'b1;
    wclk(4);
    i_sck = 1'b0;
  endtask

  // low n bits of data, MSB first; drop_last raises CS together with the final SCK rise
  task automatic send(input logic [63:0] data, input int n, input bit drop_last);
    i_cs = 1'b0;
    wclk(4);
    for (int i = n - 1; i >= 0; i--) begin
      if (drop_last && i == 0) begin
        i_mosi = data[0];
        wclk(4);
        i_sck = 1'b1;
        i_cs  = 1'b1;
        wclk(4);
        i_sck = 1'b0;
      end else begin
        send_bit(data[i]);
      end
    end
    wclk(4);
    i_cs = 1'b1;
    wclk(8);
  endtask

  task automatic rd(input string tag, input int dev, input logic [3:0] a, input logic [7:0] exp);
    i_rd_dev  = 2'(dev);
    i_rd_addr = a;
    wclk(1);
    check(tag, {56'h0, o_rd_data}, {56'h0, exp});
  endtask

  initial begin
    reset = 1'b1; i_cs = 1'b1; i_sck = 1'b0; i_mosi = 1'b0;
    i_rd_dev = 2'd0; i_rd_addr = 4'h0; i_rd_row = 3'd0;
    wclk(3);
    check("rst_rd_data", {56'h0, o_rd_data}, 64'h0);
    check("rst_row", {32'h0, o_row}, 64'h0);
    check("rst_dout", {63'h0, o_dout}, 64'h0);
    check("rst_frame", {62'h0, o_frame, o_frame_err}, 64'h0);
    reset = 1'b0;
    wclk(4);
    rd("rst_scan0", 0, 4'hB, 8'h00);

    // zero-bit frame: no latch, no pulse
    f0 = nf;
    i_cs = 1'b0; wclk(6); i_cs = 1'b1; wclk(8);
    check("empty_frame", 64'(nf - f0), 64'd0);

    // init frames
    f0 = nf; e0 = ne;
    send(64'h0F00_0F00_0F00_0F00, 64, 0);
    send(64'h0B07_0B07_0B07_0B07, 64, 0);
    send(64'h0C01_0C01_0C01_0C01, 64, 0);
    check("init_frames", 64'(nf - f0), 64'd3);
    check("init_errs", 64'(ne - e0), 64'd0);
    for (int d = 0; d < 4; d++) begin
      rd("init_test", d, 4'hF, 8'h00);
      rd("init_scan", d, 4'hB, 8'h07);
      rd("init_shdn", d, 4'hC, 8'h01);
    end
    rd("init_decode", 2, 4'h9, 8'h00);

    // row write
    send(64'h01AA_0155_01F0_010F, 64, 0);
    i_rd_row = 3'd0;
    wclk(1);
    check("row0", {32'h0, o_row}, 64'h0FF0_55AA);
    rd("dev3_digit1", 3, 4'h1, 8'hAA);
    rd("dev0_digit1", 0, 4'h1, 8'h0F);
    check("dout_after_row", {63'h0, o_dout}, 64'h0);

    // short frame: chain becomes 5501_F001_0F55_0A0B
    f0 = nf; e0 = ne;
    send(64'h55_0A0B, 24, 0);
    check("short_frame", 64'(nf - f0), 64'd1);
    check("short_err", 64'(ne - e0), 64'd1);
    rd("short_dev3_d5", 3, 4'h5, 8'h01);
    rd("short_dev2_d1", 2, 4'h1, 8'h55);
    rd("short_dev1_test", 1, 4'hF, 8'h01);
    rd("short_dev0_int", 0, 4'hA, 8'h0B);

    // no-op addresses for devices 1..3
    f0 = nf; e0 = ne;
    send(64'h0011_0022_0033_0877, 64, 0);
    rd("noop_dev0_d8", 0, 4'h8, 8'h77);
    rd("noop_dev1_d8", 1, 4'h8, 8'h00);
    rd("noop_dev1_a0", 1, 4'h0, 8'h00);
    rd("noop_dev3_d1", 3, 4'h1, 8'hAA);
    rd("noop_dev2_d1", 2, 4'h1, 8'h55);

    // SCK with CS high must not shift
    for (int i = 0; i < 64; i++) begin
      i_mosi = 1'b1; wclk(4); i_sck = 1'b1; wclk(4); i_sck = 1'b0;
    end
    i_mosi = 1'b0;
    wclk(4);
    check("idle_sck_dout", {63'h0, o_dout}, 64'h0);
    check("idle_sck_frames", 64'(nf - f0), 64'd1);

    // simultaneous CS/SCK rise: chain = {old[0], W[63:1]} = 8081_0102_0183_0208
    f0 = nf; e0 = ne;
    send(64'h0102_0204_0306_0410, 64, 1);
    check("simul_frame", 64'(nf - f0), 64'd1);
    check("simul_err", 64'(ne - e0), 64'd1);
    rd("simul_dev2_d1", 2, 4'h1, 8'h02);
    rd("simul_dev1_d1", 1, 4'h1, 8'h83);
    rd("simul_dev0_d2", 0, 4'h2, 8'h08);
    i_rd_row = 3'd0;
    wclk(1);
    check("simul_row0", {32'h0, o_row}, 64'h0F83_02AA);
    check("simul_dout", {63'h0, o_dout}, 64'h1);

    // reset mid-frame
    i_rd_dev = 2'd1; i_rd_addr = 4'h1;
    i_cs = 1'b0;
    wclk(4);
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    wclk(2);
    reset = 1'b1;
    #1;
    check("midrst_rd_data", {56'h0, o_rd_data}, 64'h0);
    check("midrst_row", {32'h0, o_row}, 64'h0);
    check("midrst_dout", {63'h0, o_dout}, 64'h0);
    check("midrst_pulses", {62'h0, o_frame, o_frame_err}, 64'h0);
    i_cs = 1'b1; i_sck = 1'b0; i_mosi = 1'b0;
    wclk(3);
    reset = 1'b0;
    wclk(4);
    rd("midrst_dev3_d1", 3, 4'h1, 8'h00);
    f0 = nf; e0 = ne;
    send(64'h0B05_0B06_0B07_0B03, 64, 0);
    check("post_frame", 64'(nf - f0), 64'd1);
    check("post_err", 64'(ne - e0), 64'd0);
    rd("post_dev3_scan", 3, 4'hB, 8'h05);
    rd("post_dev2_scan", 2, 4'hB, 8'h06);
    rd("post_dev0_scan", 0, 4'hB, 8'h03);

    check("err_without_frame", 64'(nbad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/silife_max7219_sink.md
# silife_max7219_sink

Cycle-accurate receive-side model of a daisy chain of CHAIN MAX7219 LED drivers. It oversamples the 3-wire serial bus (CS/LOAD, SCK, DIN) in the system clock domain and shifts bits through a 16·CHAIN-bit chain register. On each CS rising edge it latches every device's 16-bit word into that device's register file. It sits on the display pins, either on-chip as a loopback monitor or in the bench, so the driver's output can be checked at register level and as reconstructed cell rows.

## Interface
- CHAIN, default 4: number of chained devices; must be a power of two, ≥ 1.
- DEV_BITS, default $clog2(CHAIN) (min 1): device-index width.

- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- i_cs  input  1  LOAD/CS pin, active-low frame; asynchronous to clk.
- i_sck  input  1  serial clock pin; asynchronous to clk.
- i_mosi  input  1  DIN pin, MSB first; asynchronous to clk.
- i_rd_dev  input  DEV_BITS  device index for register read.
- i_rd_addr  input  4  register address for read (0x0–0xF).
- i_rd_row  input  3  digit row (0 = digit register 1) for row read.
- o_rd_data  output  8  registered register-read data.
- o_row  output  8·CHAIN  registered reconstructed row; o_row[8k+:8] = digit[i_rd_row+1] of device CHAIN-1-k.
- o_dout  output  1  DOUT of last device = chain register bit 16·CHAIN-1.
- o_frame  output  1  one-cycle pulse when a frame is latched.
- o_frame_err  output  1  one-cycle pulse, same cycle as o_frame, when bit count mod 16 ≠ 0.

## Operation
- Input capture: each pin passes through a 2-flop synchronizer, then a history flop. Edges are detected as stage2 vs history. Reset values are cs=1, sck=0, mosi=0, so reset release causes no events.
- Shift: a synced SCK rising edge with synced CS low (same sample) shifts the chain register left by one, with mosi entering bit 0. SCK edges while CS is high are ignored.
- Device d (d=0 next to the driver) owns chain bits [16d+15:16d]. The k-th word of a CHAIN-word frame (k from 0) lands in device CHAIN-1-k.
- The chain register is not cleared on CS fall, so short frames leave stale upper contents. This matches the physical part.
- Bit counter: 4-bit modulo-16 count plus a "nonzero" flag. Both clear on synced CS falling edge.
- CS rising edge:
  - Zero bits clocked: ignored, no latch, no pulses.
  - Otherwise every device decodes its word: bits 15:12 are ignored, bits 11:8 are the address, bits 7:0 are the data.
  - Address 0x0, 0xD, 0xE: no-op.
  - Address 0x1–0x8: digit[addr] ← data.
  - Address 0x9: decode ← data.
  - Address 0xA: intensity ← data[3:0].
  - Address 0xB: scan_limit ← data[2:0].
  - Address 0xC: shutdown_n ← data[0].
  - Address 0xF: test ← data[0].
  - o_frame pulses; o_frame_err also pulses if count ≠ 0.
- Register read returns stored values zero-extended. Addresses 0x0, 0xD and 0xE read 0x00.
- Reset values: all digit, decode, intensity, scan_limit, shutdown_n and test registers are 0. The chain register and counter are 0. o_rd_data = 0, o_row = 0, o_dout = 0, o_frame = 0, o_frame_err = 0.
- Reset mid-frame discards the partial frame. The next frame requires a fresh CS fall.

## Timing
- A pin transition sampled at edge N is visible in stage2 after edge N+1. The resulting action (shift, counter clear, latch, pulse) is committed at edge N+2.
- SCK high and low phases must each be ≥ 3 clk periods. MOSI must be stable ≥ 3 clk periods before and ≥ 1 after the SCK rise. CS must be high ≥ 3 clk periods between frames.
- If a CS rise and an SCK rise appear in the same synced sample, the SCK edge is ignored and the frame latches without it.
- o_dout updates on the same edge as the shift.
- o_rd_data and o_row are registered: 1-cycle latency from address inputs. They reflect a latch committed at edge M from edge M+1 (address held).
- Throughput: one bit per SCK period. A full frame is 16·CHAIN SCK periods plus CS overhead.

## Test plan
- Init frames: send 4× word 0x0F00, then 4× 0x0B07, then 4× 0x0C01, each as its own CS frame → each device reads test=0, scan_limit=7, shutdown_n=1; 3 o_frame pulses, no o_frame_err.
- Row write: one frame of words 0x01AA, 0x0155, 0x01F0, 0x010F (sent in that order) → i_rd_row=0 gives o_row=0x0FF055AA; device 3 digit1 = 0xAA.
- Short frame: 24 bits → o_frame and o_frame_err pulse together; all devices latch the current chain contents.
- No-op/ignore: frame with address 0x0 for devices 1–3 and 0x0877 for device 0 → only device 0 digit8 = 0x77. SCK toggled with CS high → chain register and o_dout unchanged.
- Simultaneous edges: the 16·CHAIN-th SCK rise and the CS rise in the same sample → the last bit is dropped and o_frame_err pulses.
- Reset mid-frame: assert reset after 20 bits → every output is 0 at once. A following complete frame latches correctly with no error.
